// File: rtl/rx_frame_controller.sv
// Receive frame controller: preamble hunt, SIGNAL field checks, service-field
// descrambler seeding and LSB-first PSDU byte assembly.
module rx_frame_controller #(
  parameter int PREAMBLE_BITS = 96
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        BitIn,
  input  logic        BitValid,
  input  logic        Abort,
  input  logic        DescrBit,
  output logic        SeedLoad,
  output logic [7:1]  Seed,
  output logic        DescrEnable,
  output logic        FrameStart,
  output logic        SignalValid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic [7:0]  ByteOut,
  output logic        ByteValid,
  output logic        FrameDone,
  output logic        Error,
  output logic [1:0]  ErrCode
);

  localparam int RW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(PREAMBLE_BITS);

  typedef enum logic [3:0] {
    HUNT, SIG_RATE, SIG_RSVD, SIG_LEN, SIG_PAR, SIG_TAIL, SVC_SEED, SVC_REST, PSDU
  } state_t;

  state_t      state_reg, state_next;
  logic [RW-1:0] run_reg, run_next, run_len;
  logic        last_bit_reg, last_bit_next;
  logic [3:0]  cnt_reg, cnt_next, cnt_inc;
  logic        par_reg, par_next;
  logic [3:0]  rate_sh_reg, rate_sh_next;
  logic [11:0] len_sh_reg, len_sh_next, len_full;
  logic [7:1]  seed_reg, seed_next;
  logic [7:0]  byte_sh_reg, byte_sh_next, byte_full;
  logic [11:0] byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
  logic [3:0]  rate_reg, rate_next;
  logic [11:0] length_reg, length_next;
  logic [7:0]  byte_out_reg, byte_out_next;
  logic [1:0]  err_code_reg, err_code_next, err_val;
  logic        frame_start_reg, frame_start_next;
  logic        signal_valid_reg, signal_valid_next;
  logic        byte_valid_reg, byte_valid_next;
  logic        frame_done_reg, frame_done_next;
  logic        error_reg, error_next, err_req;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg        <= HUNT;
      run_reg          <= '0;
      last_bit_reg     <= 1'b0;
      cnt_reg          <= '0;
      par_reg          <= 1'b0;
      rate_sh_reg      <= '0;
      len_sh_reg       <= '0;
      seed_reg         <= '0;
      byte_sh_reg      <= '0;
      byte_cnt_reg     <= '0;
      rate_reg         <= '0;
      length_reg       <= '0;
      byte_out_reg     <= '0;
      err_code_reg     <= '0;
      frame_start_reg  <= 1'b0;
      signal_valid_reg <= 1'b0;
      byte_valid_reg   <= 1'b0;
      frame_done_reg   <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      run_reg          <= run_next;
      last_bit_reg     <= last_bit_next;
      cnt_reg          <= cnt_next;
      par_reg          <= par_next;
      rate_sh_reg      <= rate_sh_next;
      len_sh_reg       <= len_sh_next;
      seed_reg         <= seed_next;
      byte_sh_reg      <= byte_sh_next;
      byte_cnt_reg     <= byte_cnt_next;
      rate_reg         <= rate_next;
      length_reg       <= length_next;
      byte_out_reg     <= byte_out_next;
      err_code_reg     <= err_code_next;
      frame_start_reg  <= frame_start_next;
      signal_valid_reg <= signal_valid_next;
      byte_valid_reg   <= byte_valid_next;
      frame_done_reg   <= frame_done_next;
      error_reg        <= error_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    run_next          = run_reg;
    last_bit_next     = last_bit_reg;
    cnt_next          = cnt_reg;
    par_next          = par_reg;
    rate_sh_next      = rate_sh_reg;
    len_sh_next       = len_sh_reg;
    seed_next         = seed_reg;
    byte_sh_next      = byte_sh_reg;
    byte_cnt_next     = byte_cnt_reg;
    rate_next         = rate_reg;
    length_next       = length_reg;
    byte_out_next     = byte_out_reg;
    err_code_next     = err_code_reg;
    frame_start_next  = 1'b0;
    signal_valid_next = 1'b0;
    byte_valid_next   = 1'b0;
    frame_done_next   = 1'b0;
    error_next        = 1'b0;
    err_req           = 1'b0;
    err_val           = 2'd0;
    run_len           = '0;
    cnt_inc           = cnt_reg + 4'd1;
    byte_cnt_inc      = byte_cnt_reg + 12'd1;
    len_full          = {BitIn, len_sh_reg[11:1]};
    byte_full         = {DescrBit, byte_sh_reg[7:1]};

    if (BitValid) begin
      case (state_reg)
        HUNT: begin
          // Length of the current alternating run, saturated at the preamble size.
          if (run_reg != '0 && BitIn != last_bit_reg)
            run_len = (run_reg == RUN_MAX) ? RUN_MAX : run_reg + RW'(1);
          else
            run_len = RW'(1);
          run_next      = run_len;
          last_bit_next = BitIn;
          if (!BitIn && run_len == RUN_MAX) begin
            state_next       = SIG_RATE;
            frame_start_next = 1'b1;
            err_code_next    = 2'd0;
            run_next         = '0;
            cnt_next         = '0;
            par_next         = 1'b0;
          end
        end
        SIG_RATE: begin
          par_next     = par_reg ^ BitIn;
          rate_sh_next = {rate_sh_reg[2:0], BitIn};
          cnt_next     = cnt_inc;
          if (cnt_reg == 4'd3) begin
            cnt_next = '0;
            if (!BitIn) begin
              err_req = 1'b1;
              err_val = 2'd2;
            end else begin
              state_next = SIG_RSVD;
            end
          end
        end
        SIG_RSVD: begin
          par_next = par_reg ^ BitIn;
          if (BitIn) begin
            err_req = 1'b1;
            err_val = 2'd2;
          end else begin
            state_next = SIG_LEN;
          end
        end
        SIG_LEN: begin
          par_next    = par_reg ^ BitIn;
          len_sh_next = len_full;
          cnt_next    = cnt_inc;
          if (cnt_reg == 4'd11) begin
            cnt_next = '0;
            if (len_full == 12'd0) begin
              err_req = 1'b1;
              err_val = 2'd3;
            end else begin
              state_next = SIG_PAR;
            end
          end
        end
        SIG_PAR: begin
          if (par_reg ^ BitIn) begin
            err_req = 1'b1;
            err_val = 2'd1;
          end else begin
            state_next = SIG_TAIL;
          end
        end
        SIG_TAIL: begin
          cnt_next = cnt_inc;
          if (BitIn) begin
            err_req = 1'b1;
            err_val = 2'd3;
          end else if (cnt_reg == 4'd5) begin
            state_next        = SVC_SEED;
            cnt_next          = '0;
            signal_valid_next = 1'b1;
            rate_next         = rate_sh_reg;
            length_next       = len_sh_reg;
          end
        end
        SVC_SEED: begin
          seed_next = {seed_reg[6:1], BitIn};
          cnt_next  = cnt_inc;
          if (cnt_reg == 4'd6) begin
            state_next = SVC_REST;
            cnt_next   = '0;
          end
        end
        SVC_REST: begin
          cnt_next = cnt_inc;
          if (cnt_reg == 4'd8) begin
            state_next    = PSDU;
            cnt_next      = '0;
            byte_cnt_next = '0;
          end
        end
        PSDU: begin
          byte_sh_next = byte_full;
          cnt_next     = cnt_inc;
          if (cnt_reg == 4'd7) begin
            cnt_next        = '0;
            byte_out_next   = byte_full;
            byte_valid_next = 1'b1;
            byte_cnt_next   = byte_cnt_inc;
            if (byte_cnt_inc == length_reg) begin
              frame_done_next = 1'b1;
              state_next      = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end

    if (err_req) begin
      error_next    = 1'b1;
      err_code_next = err_val;
      state_next    = HUNT;
      cnt_next      = '0;
    end

    // Abort outranks everything decided above, including a final byte or an error.
    if (Abort) begin
      state_next        = HUNT;
      cnt_next          = '0;
      run_next          = '0;
      frame_start_next  = 1'b0;
      signal_valid_next = 1'b0;
      byte_valid_next   = 1'b0;
      frame_done_next   = 1'b0;
      error_next        = 1'b0;
      err_code_next     = err_code_reg;
      rate_next         = rate_reg;
      length_next       = length_reg;
      byte_out_next     = byte_out_reg;
    end
  end

  assign SeedLoad    = BitValid && state_reg == SVC_REST && cnt_reg == 4'd0;
  assign DescrEnable = BitValid && (state_reg == SVC_REST || state_reg == PSDU);
  assign Seed        = seed_reg;
  assign FrameStart  = frame_start_reg;
  assign SignalValid = signal_valid_reg;
  assign Rate        = rate_reg;
  assign Length      = length_reg;
  assign ByteOut     = byte_out_reg;
  assign ByteValid   = byte_valid_reg;
  assign FrameDone   = frame_done_reg;
  assign Error       = error_reg;
  assign ErrCode     = err_code_reg;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: frames built bit by bit from field values,
// expected results derived from the field rules, pulses tallied by a monitor.
module tb_rx_frame_controller;

  logic        Clock = 1'b0;
  logic        Reset, BitIn, BitValid, Abort, DescrBit;
  logic        SeedLoad, DescrEnable, FrameStart, SignalValid;
  logic [7:1]  Seed;
  logic [3:0]  Rate;
  logic [11:0] Length;
  logic [7:0]  ByteOut;
  logic        ByteValid, FrameDone, Error;
  logic [1:0]  ErrCode;

  rx_frame_controller #(.PREAMBLE_BITS(96)) dut (
    .Clock(Clock), .Reset(Reset), .BitIn(BitIn), .BitValid(BitValid),
    .Abort(Abort), .DescrBit(DescrBit), .SeedLoad(SeedLoad), .Seed(Seed),
    .DescrEnable(DescrEnable), .FrameStart(FrameStart), .SignalValid(SignalValid),
    .Rate(Rate), .Length(Length), .ByteOut(ByteOut), .ByteValid(ByteValid),
    .FrameDone(FrameDone), .Error(Error), .ErrCode(ErrCode)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail = 0;
  int fs_cnt = 0, sv_cnt = 0, err_cnt = 0, sl_cnt = 0, fd_cnt = 0;
  int fd_alone = 0, bv_idle = 0, de_cnt = 0, de_bad = 0;
  logic [7:1] seed_cap = '0;
  logic       prev_bv = 1'b0;
  logic [7:0] got_bytes[$];
  bit         gap = 0;

  logic [3:0]  exp_rate = '0;
  logic [11:0] exp_len = '0;
  logic [1:0]  exp_code = '0;

  always @(negedge Clock) begin
    if (FrameStart) fs_cnt <= fs_cnt + 1;
    if (SignalValid) sv_cnt <= sv_cnt + 1;
    if (Error) err_cnt <= err_cnt + 1;
    if (SeedLoad) begin
      sl_cnt   <= sl_cnt + 1;
      seed_cap <= Seed;
    end
    if (DescrEnable) de_cnt <= de_cnt + 1;
    if (DescrEnable && !BitValid) de_bad <= de_bad + 1;
    if (ByteValid) begin
      got_bytes.push_back(ByteOut);
      if (!prev_bv) bv_idle <= bv_idle + 1;
    end
    if (FrameDone) begin
      fd_cnt <= fd_cnt + 1;
      if (!ByteValid) fd_alone <= fd_alone + 1;
    end
    prev_bv <= BitValid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic b, input logic d, input logic ab);
    logic [1:0] r;
    BitIn = b; DescrBit = d; BitValid = 1'b1; Abort = ab;
    @(posedge Clock); #1;
    r = 2'($urandom);
    BitValid = 1'b0; Abort = 1'b0; BitIn = r[0]; DescrBit = r[1];
    if (gap) begin
      @(posedge Clock); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_header(input logic [3:0] rate, input logic rsvd, input logic [11:0] len,
                             input logic flip, input logic [5:0] tail, input bit lead0);
    logic p;
    if (lead0) put(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 96; i++) put((i % 2) == 0, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) put(rate[i], 1'b0, 1'b0);
    put(rsvd, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) put(len[i], 1'b0, 1'b0);
    p = (^rate) ^ rsvd ^ (^len) ^ flip;
    put(p, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) put(tail[i], 1'b0, 1'b0);
  endtask

  task automatic send_service(output logic [7:1] seed_exp);
    logic [15:0] svc;
    svc = 16'($urandom);
    for (int i = 0; i < 7; i++) seed_exp[7 - i] = svc[i];
    for (int i = 0; i < 16; i++) put(svc[i], 1'b0, 1'b0);
  endtask

  task automatic do_frame(input string nm, input logic [3:0] rate, input logic rsvd,
                          input logic [11:0] len, input logic flip, input logic [5:0] tail,
                          input bit lead0, input bit abort_last);
    int fs0, sv0, err0, sl0, fd0, fda0, bvi0, de0, deb0, nexp;
    logic [1:0] code;
    logic [7:1] seed_exp;
    logic [7:0] pay[$];
    logic [7:0] b;
    fs0 = fs_cnt; sv0 = sv_cnt; err0 = err_cnt; sl0 = sl_cnt; fd0 = fd_cnt;
    fda0 = fd_alone; bvi0 = bv_idle; de0 = de_cnt; deb0 = de_bad;
    got_bytes.delete();
    if (!rate[0])       code = 2'd2;
    else if (rsvd)      code = 2'd2;
    else if (len == 0)  code = 2'd3;
    else if (flip)      code = 2'd1;
    else if (tail != 0) code = 2'd3;
    else                code = 2'd0;
    exp_code = 2'd0;
    send_header(rate, rsvd, len, flip, tail, lead0);
    if (code == 2'd0) begin
      exp_rate = rate;
      exp_len  = len;
      send_service(seed_exp);
      for (int k = 0; k < int'(len); k++) begin
        b = 8'($urandom);
        pay.push_back(b);
        for (int i = 0; i < 8; i++)
          put(1'($urandom), b[i], abort_last && k == int'(len) - 1 && i == 7);
      end
    end else begin
      exp_code = code;
    end
    idle(3);
    $display("frame %s rate=%b len=%0d code=%0d bytes=%0d", nm, rate, len, code, got_bytes.size());
    chk({nm, "_framestart"}, fs_cnt - fs0, 1);
    chk({nm, "_errcode"}, ErrCode, exp_code);
    chk({nm, "_rate"}, Rate, exp_rate);
    chk({nm, "_length"}, Length, exp_len);
    if (code != 2'd0) begin
      chk({nm, "_error"}, err_cnt - err0, 1);
      chk({nm, "_no_sigvalid"}, sv_cnt - sv0, 0);
      chk({nm, "_no_seedload"}, sl_cnt - sl0, 0);
      chk({nm, "_no_bytes"}, got_bytes.size(), 0);
    end else begin
      nexp = abort_last ? int'(len) - 1 : int'(len);
      chk({nm, "_no_error"}, err_cnt - err0, 0);
      chk({nm, "_sigvalid"}, sv_cnt - sv0, 1);
      chk({nm, "_seedload"}, sl_cnt - sl0, 1);
      chk({nm, "_seed"}, seed_cap, seed_exp);
      chk({nm, "_nbytes"}, got_bytes.size(), nexp);
      for (int k = 0; k < nexp && k < got_bytes.size(); k++)
        chk($sformatf("%s_byte%0d", nm, k), got_bytes[k], pay[k]);
      chk({nm, "_framedone"}, fd_cnt - fd0, abort_last ? 0 : 1);
      chk({nm, "_fd_with_bv"}, fd_alone - fda0, 0);
      chk({nm, "_bv_idle"}, bv_idle - bvi0, 0);
      chk({nm, "_de_idle"}, de_bad - deb0, 0);
      if (!abort_last) chk({nm, "_de_count"}, de_cnt - de0, 9 + 8 * int'(len));
    end
  endtask

  initial begin
    logic [7:1]  seed_dummy;
    logic [31:0] r;
    int fs0, fd0;
    Reset = 1'b1; BitIn = 1'b0; BitValid = 1'b0; Abort = 1'b0; DescrBit = 1'b0;
    idle(3);
    chk("reset_outputs", {31'd0, |{SeedLoad, Seed, DescrEnable, FrameStart, SignalValid, Rate,
                                   Length, ByteOut, ByteValid, FrameDone, Error, ErrCode}}, 0);
    Reset = 1'b0;
    idle(2);

    do_frame("basic", 4'b1101, 1'b0, 12'd3, 1'b0, 6'd0, 0, 0);
    do_frame("parity", 4'b1101, 1'b0, 12'd3, 1'b1, 6'd0, 0, 0);
    r = $urandom;
    do_frame("after_par", {r[2:0], 1'b1}, 1'b0, 12'($urandom_range(1, 5)), 1'b0, 6'd0, 0, 0);
    do_frame("rsvd", 4'b1101, 1'b1, 12'd3, 1'b0, 6'd0, 0, 0);
    do_frame("len0", 4'b1101, 1'b0, 12'd0, 1'b0, 6'd0, 0, 0);
    do_frame("rate_lsb0", 4'b1100, 1'b0, 12'd3, 1'b0, 6'd0, 0, 0);
    do_frame("tail", 4'b1011, 1'b0, 12'd2, 1'b0, 6'b000100, 0, 0);
    do_frame("long_pre", 4'b1111, 1'b0, 12'd2, 1'b0, 6'd0, 1, 0);
    gap = 1;
    do_frame("gapped", 4'b0101, 1'b0, 12'd4, 1'b0, 6'd0, 0, 0);
    gap = 0;
    do_frame("abort", 4'b1101, 1'b0, 12'd3, 1'b0, 6'd0, 0, 1);
    do_frame("after_abort", 4'b1001, 1'b0, 12'd2, 1'b0, 6'd0, 0, 0);

    // Reset in the middle of the second PSDU byte.
    fd0 = fd_cnt;
    got_bytes.delete();
    send_header(4'b1101, 1'b0, 12'd3, 1'b0, 6'd0, 0);
    send_service(seed_dummy);
    for (int i = 0; i < 11; i++) put(1'($urandom), 1'($urandom), 1'b0);
    Reset = 1'b1;
    #1;
    chk("midreset_outputs", {31'd0, |{SeedLoad, Seed, DescrEnable, FrameStart, SignalValid, Rate,
                                      Length, ByteOut, ByteValid, FrameDone, Error, ErrCode}}, 0);
    idle(2);
    Reset = 1'b0;
    exp_rate = '0; exp_len = '0; exp_code = '0;
    idle(4);
    chk("midreset_no_framedone", fd_cnt - fd0, 0);
    chk("midreset_one_byte", got_bytes.size(), 1);
    $display("reset mid-frame bytes=%0d", got_bytes.size());

    // 95-bit preamble broken by a repeated 1 must not start a frame.
    fs0 = fs_cnt;
    for (int i = 0; i < 95; i++) put((i % 2) == 0, 1'b0, 1'b0);
    put(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) put(1'($urandom), 1'b0, 1'b0);
    idle(3);
    chk("short_pre_no_start", fs_cnt - fs0, 0);
    $display("short preamble framestarts=%0d", fs_cnt - fs0);

    for (int n = 0; n < 3; n++) begin
      r = $urandom;
      gap = r[8];
      do_frame($sformatf("rand%0d", n), {r[2:0], 1'b1}, 1'b0, 12'($urandom_range(1, 5)),
               1'b0, 6'd0, 0, 0);
    end
    gap = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): PREAMBLE_BITS, 96, number of alternating bits forming the PLCP preamble.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 BitIn  input  1  received (scrambled) serial bit, qualified by BitValid.
REQ-005 BitValid  input  1  BitIn carries a new bit this cycle; the block SHALL advance only on BitValid cycles.
REQ-006 Abort  input  1  synchronous frame abort.
REQ-007 DescrBit  input  1  descrambled bit from the external descrambler, combinational from BitIn, valid in the same cycle.
REQ-008 SeedLoad  output  1  one-cycle descrambler seed-load strobe.
REQ-009 Seed  output  7  descrambler seed, Seed[1] = most recent bit.
REQ-010 DescrEnable  output  1  descrambler advance enable.
REQ-011 FrameStart  output  1  one-cycle pulse on preamble detect.
REQ-012 SignalValid  output  1  one-cycle pulse when SIGNAL is accepted.
REQ-013 Rate  output  4  decoded RATE, Rate[3] = first received bit.
REQ-014 Length  output  12  PSDU octet count, Length[0] = first received bit.
REQ-015 ByteOut  output  8  PSDU byte, bit 0 = first received bit.
REQ-016 ByteValid  output  1  one-cycle pulse qualifying ByteOut.
REQ-017 FrameDone  output  1  one-cycle pulse, coincident with the last ByteValid.
REQ-018 Error  output  1  one-cycle pulse on SIGNAL rejection.
REQ-019 ErrCode  output  2  cause of the last error, held until the next FrameStart: 1 = parity, 2 = rate/reserved, 3 = zero length/tail.

Function
REQ-020 States SHALL be HUNT, SIG_RATE(4), SIG_RSVD(1), SIG_LEN(12), SIG_PAR(1), SIG_TAIL(6), SVC_SEED(7), SVC_REST(9) and PSDU(8*Length); the parenthesised value is the number of BitValid bits consumed in that state.
REQ-021 HUNT SHALL detect the preamble when the last PREAMBLE_BITS valid bits alternate and the current bit is 0 (12 x 8'hAA, oldest bit 1); detection SHALL use a run counter, not a 96-bit shift register.
REQ-022 On detection the block SHALL pulse FrameStart the next cycle, clear ErrCode and enter SIG_RATE; the next valid bit is RATE bit 1.
REQ-023 A preamble run longer than PREAMBLE_BITS SHALL trigger on the first qualifying bit only.
REQ-024 SIG_PAR SHALL check even parity over RATE, reserved, LENGTH and the parity bit (18 bits); a mismatch SHALL raise Error with ErrCode=1 and return to HUNT.
REQ-025 In SIG_RSVD, a reserved bit of 1 SHALL raise Error with ErrCode=2; a RATE whose LSB (last bit) is 0 SHALL raise ErrCode=2 at the end of SIG_RATE; both SHALL return to HUNT.
REQ-026 Length 0, checked at the end of SIG_LEN, or any nonzero tail bit SHALL raise Error with ErrCode=3 and return to HUNT.
REQ-027 After the 6th tail bit the block SHALL pulse SignalValid and update the Rate/Length outputs in the same cycle; the outputs SHALL hold until the next SignalValid.
REQ-028 SVC_SEED SHALL shift the 7 raw service bits into Seed; in the cycle the 8th service bit is valid, SeedLoad=1 and DescrEnable=1.
REQ-029 DescrEnable SHALL equal BitValid from the 8th service bit to the last PSDU bit, and 0 otherwise.
REQ-030 PSDU SHALL pack DescrBit LSB-first; ByteValid SHALL pulse one cycle after the BitValid carrying the 8th bit, with ByteOut stable in that cycle.
REQ-031 The 12-bit byte counter SHALL compare against Length; on byte Length the block SHALL pulse FrameDone with ByteValid and return to HUNT.
REQ-032 Abort SHALL force HUNT on the next edge and suppress ByteValid, FrameDone and Error in that cycle; Abort SHALL win over a simultaneous last bit or error.
REQ-033 Cycles with BitValid=0 SHALL hold all state; the pulse outputs SHALL be 0 in those cycles except a pending registered pulse.

Reset
REQ-034 Reset SHALL force HUNT, clear all counters and Seed, set every output to 0 including Rate and Length, and take effect mid-frame without emitting any pulse.

Verification
REQ-035 96 alternating bits (1 first) + RATE 1101, rsvd 0, LENGTH 3 (LSB first), parity 1, tail 0, 16 service bits, 24 PSDU bits -> FrameStart, SignalValid with Rate=4'b1101, Length=3, SeedLoad once, 3 ByteValid, FrameDone with the 3rd byte.
REQ-036 Same frame with the parity bit flipped to 0 -> Error, ErrCode=1, no SignalValid, back in HUNT; an immediate valid frame is then received.
REQ-037 Same frame with the reserved bit 1 -> ErrCode=2; with LENGTH 0 -> ErrCode=3.
REQ-038 BitValid toggling 1/0 across the whole frame -> identical bytes and ordering, ByteValid never in a BitValid=0 cycle except the registered pulse.
REQ-039 Abort asserted together with the last PSDU bit -> no ByteValid or FrameDone, HUNT next cycle.
REQ-040 Reset asserted during PSDU byte 2 -> all outputs 0 immediately, no FrameDone; a 95-bit preamble followed by a 1 -> no FrameStart.
